alu_share_arbiter: RTL and testbench

//  Shares one multi-cycle, non-pipelined 64-bit ALU between N_REQ requesters.
//  - Grants are round-robin. One operation is in flight at a time.
//  - Latches the winner's operands, pulses them into the ALU and waits for the ALU result.
//  - Returns the result to the winning requester over a valid/ready response channel.
//  - Sits between the requesters (issue/LSU-style clients) and the ALU instance.

---
 rtl/alu_share_arbiter.sv | 137 +++++++++++++
 tb/tb_alu_share_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin arbiter sharing one multi-cycle ALU among N_REQ requesters
// Optional WAIT-state watchdog enabled by defining ALU_WATCHDOG_EN.
module alu_share_arbiter #(
    parameter int N_REQ          = 4,
    parameter int DATA_W         = 64,
    parameter int OP_W           = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*DATA_W-1:0] req_a,
    input  logic [N_REQ*DATA_W-1:0] req_b,
    input  logic [N_REQ*OP_W-1:0]   req_op,
    output logic [N_REQ-1:0]        rsp_valid,
    input  logic [N_REQ-1:0]        rsp_ready,
    output logic [DATA_W-1:0]       rsp_z,
    output logic                    rsp_err,
    output logic                    alu_valid,
    output logic [DATA_W-1:0]       alu_a,
    output logic [DATA_W-1:0]       alu_b,
    output logic [OP_W-1:0]         alu_op,
    input  logic                    alu_done,
    input  logic [DATA_W-1:0]       alu_z
);
    localparam int IDX_W = (N_REQ <= 2) ? 1 : $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   gnt;
    logic [IDX_W-1:0]   win;
    logic [IDX_W-1:0]   idx;
    logic               win_found;
    logic [N_REQ-1:0]   gnt_onehot;

    logic [DATA_W-1:0]  a_arr  [N_REQ];
    logic [DATA_W-1:0]  b_arr  [N_REQ];
    logic [OP_W-1:0]    op_arr [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign a_arr[i]  = req_a[i*DATA_W +: DATA_W];
        assign b_arr[i]  = req_b[i*DATA_W +: DATA_W];
        assign op_arr[i] = req_op[i*OP_W +: OP_W];
    end

    // Scan starts one past the last winner so a persistent requester cannot starve the rest.
    always_comb begin
        win_found = 1'b0;
        win       = '0;
        idx       = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = IDX_W'((int'(rr_ptr) + k) % N_REQ);
            if (!win_found && req_valid[idx]) begin
                win_found = 1'b1;
                win       = idx;
            end
        end
    end

    assign req_ready  = (state == IDLE && win_found) ? (N_REQ'(1) << win) : '0;
    assign gnt_onehot = N_REQ'(1) << gnt;

`ifdef ALU_WATCHDOG_EN
    logic [7:0] wd_cnt;
    logic       err_q;
    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= IDX_W'(N_REQ - 1);
            gnt       <= '0;
            alu_valid <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            rsp_valid <= '0;
            rsp_z     <= '0;
`ifdef ALU_WATCHDOG_EN
            wd_cnt    <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        alu_a     <= a_arr[win];
                        alu_b     <= b_arr[win];
                        alu_op    <= op_arr[win];
                        gnt       <= win;
                        rr_ptr    <= win;
                        alu_valid <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    // A done coinciding with the strobe is ignored: it cannot belong to this operation.
                    alu_valid <= 1'b0;
                    state     <= WAIT;
`ifdef ALU_WATCHDOG_EN
                    wd_cnt    <= '0;
`endif
                end
                WAIT: begin
                    if (alu_done) begin
                        rsp_z     <= alu_z;
                        rsp_valid <= gnt_onehot;
                        state     <= RESP;
`ifdef ALU_WATCHDOG_EN
                        err_q     <= 1'b0;
                    end else if (wd_cnt == 8'(TIMEOUT_CYCLES - 1)) begin
                        rsp_z     <= '0;
                        err_q     <= 1'b1;
                        rsp_valid <= gnt_onehot;
                        state     <= RESP;
                    end else begin
                        wd_cnt    <= wd_cnt + 8'd1;
`endif
                    end
                end
                RESP: begin
                    if (rsp_ready[gnt]) begin
                        rsp_valid <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - randomized + directed self-checking bench for alu_share_arbiter
module tb_alu_share_arbiter;
    localparam int N  = 4;
    localparam int DW = 64;
    localparam int OW = 4;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*DW-1:0] req_a = '0;
    logic [N*DW-1:0] req_b = '0;
    logic [N*OW-1:0] req_op = '0;
    logic [N-1:0]    rsp_valid;
    logic [N-1:0]    rsp_ready = '1;
    logic [DW-1:0]   rsp_z;
    logic            rsp_err;
    logic            alu_valid;
    logic [DW-1:0]   alu_a;
    logic [DW-1:0]   alu_b;
    logic [OW-1:0]   alu_op;
    logic            alu_done = 1'b0;
    logic [DW-1:0]   alu_z = '0;

    alu_share_arbiter #(.N_REQ(N), .DATA_W(DW), .OP_W(OW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_z(rsp_z), .rsp_err(rsp_err),
        .alu_valid(alu_valid), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_done(alu_done), .alu_z(alu_z)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] golden(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input logic [OW-1:0] op);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << b[5:0];
            default: return ~a;
        endcase
    endfunction

    function automatic int winner(input logic [N-1:0] v, input int rr);
        for (int k = 1; k <= N; k++)
            if (v[(rr + k) % N]) return (rr + k) % N;
        return -1;
    endfunction

    // Transaction-level reference: phase 0 free, 1 strobe, 2 awaiting result, 3 returning result.
    int            ph = 0;
    int            m_rr = N - 1;
    int            m_g = 0;
    int            m_wd = 0;
    logic [DW-1:0] m_a = '0, m_b = '0, m_z = '0;
    logic [OW-1:0] m_op = '0;
    logic          m_err = 1'b0;

    int            grants[$];
    logic [N-1:0]  rl_v[$];
    logic [DW-1:0] rl_z[$];
    logic          rl_e[$];
    int            alu_pulses = 0;
    int            stall_cycles = 0;

    int            alu_lat = 2;
    int            alu_cnt = 0;
    logic [DW-1:0] alu_res = '0;
    bit            spur_en = 1'b0;

    always @(negedge clk) begin
        int w;
        logic [N-1:0] er, ev;
        er = '0;
        ev = '0;
        if (ph == 0) begin
            w = winner(req_valid, m_rr);
            if (w >= 0) er[w] = 1'b1;
        end
        if (ph == 3) ev[m_g] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(er));
        chk("alu_valid", 64'(alu_valid), 64'(ph == 1));
        chk("alu_a", alu_a, m_a);
        chk("alu_b", alu_b, m_b);
        chk("alu_op", 64'(alu_op), 64'(m_op));
        chk("rsp_valid", 64'(rsp_valid), 64'(ev));
        chk("rsp_z", rsp_z, m_z);
        chk("rsp_err", 64'(rsp_err), 64'(m_err));

        if (!rst) begin
            for (int i = 0; i < N; i++)
                if (req_valid[i] && req_ready[i]) grants.push_back(i);
            if ((rsp_valid & rsp_ready) != '0) begin
                rl_v.push_back(rsp_valid);
                rl_z.push_back(rsp_z);
                rl_e.push_back(rsp_err);
            end
            if (rsp_valid == 4'b0010 && !rsp_ready[1]) stall_cycles++;
            if (alu_valid) begin
                alu_pulses++;
                alu_cnt = alu_lat;
                alu_res = golden(alu_a, alu_b, alu_op);
            end
        end

        if (rst) begin
            ph = 0; m_rr = N - 1; m_g = 0;
            m_a = '0; m_b = '0; m_op = '0; m_z = '0; m_err = 1'b0;
        end else begin
            case (ph)
                0: begin
                    w = winner(req_valid, m_rr);
                    if (w >= 0) begin
                        m_a  = req_a[w*DW +: DW];
                        m_b  = req_b[w*DW +: DW];
                        m_op = req_op[w*OW +: OW];
                        m_g = w; m_rr = w; ph = 1;
                    end
                end
                1: begin ph = 2; m_wd = 0; end
                2: begin
                    if (alu_done) begin
                        m_z = golden(m_a, m_b, m_op); m_err = 1'b0; ph = 3;
                    end else begin
`ifdef ALU_WATCHDOG_EN
                        m_wd++;
                        if (m_wd == TO) begin m_z = '0; m_err = 1'b1; ph = 3; end
`endif
                    end
                end
                default: if (rsp_ready[m_g]) ph = 0;
            endcase
        end
    end

    // ALU stand-in: result after alu_lat cycles, plus stray done pulses outside the wait phase.
    always begin
        bit fire;
        @(posedge clk);
        #2;
        fire = 1'b0;
        if (rst) alu_cnt = 0;
        else if (alu_cnt > 0) begin
            alu_cnt--;
            if (alu_cnt == 0) fire = 1'b1;
        end
        alu_done = fire;
        alu_z    = fire ? alu_res : '0;
        if (!fire && !rst && spur_en && ph != 2 && $urandom_range(7) == 0) begin
            alu_done = 1'b1;
            alu_z    = {$urandom, $urandom};
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_req(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [OW-1:0] op);
        req_a[i*DW +: DW] = a;
        req_b[i*DW +: DW] = b;
        req_op[i*OW +: OW] = op;
    endtask

    function automatic int gnt_at(input int k);
        return (k >= 0 && k < grants.size()) ? grants[k] : 99;
    endfunction

    function automatic logic [DW-1:0] last_z();
        return (rl_z.size() > 0) ? rl_z[rl_z.size()-1] : 64'hdead_dead;
    endfunction

    initial begin
        int s, p;
        int e2[5] = '{0, 1, 2, 3, 0};

        cyc(2);
        rst = 1'b0;

        // single request: 5 + 3 with a 4-cycle ALU
        s = grants.size(); p = alu_pulses; alu_lat = 4;
        set_req(0, 64'd5, 64'd3, 4'd0);
        req_valid = 4'b0001;
        cyc(1);
        req_valid = '0;
        cyc(12);
        chk("t1_ngrant", 64'(grants.size() - s), 64'd1);
        chk("t1_gnt", 64'(gnt_at(s)), 64'd0);
        chk("t1_pulses", 64'(alu_pulses - p), 64'd1);
        chk("t1_rsp_valid", 64'((rl_v.size() > 0) ? rl_v[rl_v.size()-1] : 4'hf), 64'd1);
        chk("t1_rsp_z", last_z(), 64'd8);
        chk("t1_rsp_err", 64'((rl_e.size() > 0) ? rl_e[rl_e.size()-1] : 1'b1), 64'd0);

        // all four requesting after reset
        rst = 1'b1; cyc(1); rst = 1'b0;
        s = grants.size(); p = alu_pulses; alu_lat = 2;
        for (int i = 0; i < N; i++) set_req(i, 64'(i * 10), 64'd1, 4'd0);
        req_valid = 4'b1111;
        cyc(22);
        req_valid = '0;
        cyc(10);
        for (int k = 0; k < 5; k++) chk($sformatf("t2_gnt%0d", k), 64'(gnt_at(s + k)), 64'(e2[k]));
        chk("t2_pulses", 64'(alu_pulses - p), 64'(grants.size() - s));

        // response stalled for requester 1; other rsp_ready bits must not release it
        rst = 1'b1; cyc(1); rst = 1'b0;
        stall_cycles = 0;
        set_req(1, 64'd100, 64'd1, 4'd1);
        rsp_ready = 4'b1101;
        req_valid = 4'b0010;
        cyc(1);
        req_valid = '0;
        cyc(8);
        s = grants.size();
        req_valid = 4'b1111;
        cyc(10);
        chk("t3_no_grant", 64'(grants.size() - s), 64'd0);
        rsp_ready = 4'b1111;
        req_valid = '0;
        cyc(3);
        chk("t3_stall", 64'(stall_cycles), 64'd15);
        chk("t3_rsp_z", last_z(), 64'd99);

        // reset while waiting on the ALU
        set_req(0, 64'd5, 64'd9, 4'd3);
        alu_lat = 10;
        req_valid = 4'b0001;
        cyc(1);
        req_valid = '0;
        cyc(3);
        rst = 1'b1; cyc(1); rst = 1'b0;
        chk("t5_alu_a", alu_a, 64'd0);
        chk("t5_rsp_valid", 64'(rsp_valid), 64'd0);
        alu_lat = 2;
        s = grants.size();
        set_req(2, 64'd7, 64'd6, 4'd2);
        req_valid = 4'b0100;
        cyc(1);
        req_valid = '0;
        cyc(8);
        chk("t5_gnt", 64'(gnt_at(s)), 64'd2);
        chk("t5_rsp_z", last_z(), 64'd6);

        // requester 0 just served, then 0 and 2 together
        req_valid = 4'b0001;
        cyc(1);
        req_valid = '0;
        cyc(8);
        s = grants.size();
        req_valid = 4'b0101;
        cyc(7);
        req_valid = '0;
        cyc(8);
        chk("t6_first", 64'(gnt_at(s)), 64'd2);
        chk("t6_second", 64'(gnt_at(s + 1)), 64'd0);

`ifdef ALU_WATCHDOG_EN
        rst = 1'b1; cyc(1); rst = 1'b0;
        alu_lat = 40;
        set_req(0, 64'd1, 64'd1, 4'd0);
        req_valid = 4'b0001;
        cyc(1);
        req_valid = '0;
        cyc(45);
        chk("t4_err", 64'((rl_e.size() > 0) ? rl_e[rl_e.size()-1] : 1'b0), 64'd1);
        chk("t4_z", last_z(), 64'd0);
        alu_lat = 2;
        req_valid = 4'b0001;
        cyc(1);
        req_valid = '0;
        cyc(8);
        chk("t4_next_z", last_z(), 64'd2);
`endif

        // randomized traffic, stray done pulses and occasional reset
        spur_en = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(299) == 0);
            req_valid = N'($urandom);
            for (int i = 0; i < N; i++)
                set_req(i, {$urandom, $urandom}, {$urandom, $urandom}, OW'($urandom));
            rsp_ready = N'($urandom);
`ifdef ALU_WATCHDOG_EN
            alu_lat = ($urandom_range(9) == 0) ? 30 : int'($urandom_range(6, 1));
`else
            alu_lat = int'($urandom_range(6, 1));
`endif
            cyc(1);
        end
        rst = 1'b0;
        req_valid = '0;
        rsp_ready = '1;
        spur_en = 1'b0;
        cyc(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
